// File: rtl/btn_debounce.sv
// Per-channel button debouncer with press/release pulses and sticky press-pending flags.
// A change is accepted after DEBOUNCE_CYCLES+1 consecutive identical samples.
module btn_debounce #(
    parameter int unsigned N_BTN           = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_sync,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] press_pending,
    input  logic [N_BTN-1:0] press_ack,
    output logic             any_pending,
    output logic             overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARM_HI = 2'd1;
    localparam logic [1:0] S_HELD   = 2'd2;
    localparam logic [1:0] S_ARM_LO = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] r_pend;
    logic             r_ovr;
    logic             w_ovr_set;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        logic [1:0]       r_state;
        logic [1:0]       w_state_d;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_d;
        logic             r_level;
        logic             r_press;
        logic             r_release;
        logic             w_rise;
        logic             w_fall;

        always_comb begin
            w_state_d = r_state;
            w_cnt_d   = r_cnt;
            w_rise    = 1'b0;
            w_fall    = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (btn_sync[g]) begin
                        w_state_d = S_ARM_HI;
                        w_cnt_d   = '0;
                    end
                end
                S_ARM_HI: begin
                    if (!btn_sync[g]) begin
                        w_state_d = S_IDLE;
                    end else if (r_cnt == CNT_MAX) begin
                        w_state_d = S_HELD;
                        w_rise    = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (!btn_sync[g]) begin
                        w_state_d = S_ARM_LO;
                        w_cnt_d   = '0;
                    end
                end
                S_ARM_LO: begin
                    if (btn_sync[g]) begin
                        w_state_d = S_HELD;
                    end else if (r_cnt == CNT_MAX) begin
                        w_state_d = S_IDLE;
                        w_fall    = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                end
            endcase
        end

        // Level and pulses are registered from the next state so they change together.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_d;
                r_cnt     <= w_cnt_d;
                r_level   <= (w_state_d == S_HELD) || (w_state_d == S_ARM_LO);
                r_press   <= w_rise;
                r_release <= w_fall;
            end
        end

        assign btn_level[g]     = r_level;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
    end

    // A new press beats a same-cycle ack; overrun only when the old press was never acked.
    assign w_ovr_set = |(press_pulse & r_pend & ~press_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_ovr  <= 1'b0;
        end else begin
            r_pend <= press_pulse | (r_pend & ~press_ack);
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign press_pending = r_pend;
    assign any_pending   = |r_pend;
    assign overrun       = r_ovr;

endmodule
